wb_stage_multi: RTL and testbench
=================================

WB_STAGE_MULTI -- requirements
Module: wb_stage_multi

Interface
REQ-001 SHALL have parameters (one per line: name, default, meaning):
  NLANE, 2, issue lanes per bundle; lane 0 is oldest
  XLEN, 32, data and PC width
  RD_W, 5, register index width
  EC_W, 7, exception code width
  EC_INT, 7'h00, ecode reported for an interrupt
REQ-002 SHALL have ports (one per line: name, direction, width, meaning):
  clk  in  1  clock
  rst  in  1  reset
  flush  in  1  kill held bundle and incoming bundle
  irq  in  1  interrupt pending, taken at commit on lane 0
  in_valid  in  1  bundle offered
  in_ready  out  1  bundle accepted when in_valid&in_ready
  in_pc  in  NLANE*XLEN  per-lane PC
  in_inst  in  NLANE*32  per-lane instruction word
  in_rd  in  NLANE*RD_W  per-lane destination
  in_we  in  NLANE  per-lane register write intent
  in_src  in  NLANE*2  result source: 0 alu, 1 div, 2 csr, 3 load
  in_alu  in  NLANE*XLEN  alu/mul result
  in_exc  in  NLANE  lane raised exception
  in_ecode  in  NLANE*EC_W  per-lane ecode
  in_badv  in  NLANE*XLEN  per-lane bad address
  csr_data  in  XLEN  csr read data, valid on acceptance cycle
  div_valid  in  1  divider result strobe
  div_data  in  XLEN  divider result
  ld_valid  in  1  load result strobe
  ld_data  in  XLEN  load result
  wb_we  out  NLANE  registered write enables
  wb_rd  out  NLANE*RD_W  registered destinations
  wb_data  out  NLANE*XLEN  registered write data
  exc_valid  out  1  one-cycle exception/interrupt commit pulse
  exc_ecode  out  EC_W  committed ecode
  exc_era  out  XLEN  PC of excepting lane
  exc_badv  out  XLEN  badv of excepting lane
  dbg_valid  out  NLANE  lane retired this cycle
  dbg_pc  out  NLANE*XLEN  retired PC
  dbg_inst  out  NLANE*32  retired instruction
REQ-003 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 SHALL hold one bundle in a hold register H with state EMPTY or WAIT; H holds pending bits P[NLANE].
REQ-005 On acceptance, csr lanes SHALL capture csr_data; P[i] SHALL be set for div/load lanes not killed by REQ-009.
REQ-006 In WAIT, div_valid SHALL clear the div pending bit and capture div_data; ld_valid likewise for load; strobes in EMPTY or with no matching pending lane SHALL be ignored.
REQ-007 At most one div lane and one load lane per bundle; otherwise behaviour is undefined (bench assertion).
REQ-008 H SHALL commit on the edge where state is WAIT and P, after that cycle's strobes, is zero; wb_*/dbg_*/exc_* register at that edge; a strobe arriving the same cycle completes and commits in that cycle.
REQ-009 Kill rule: k = lowest lane with in_exc (lane 0 if irq at commit); lanes >= k SHALL have wb_we=0, dbg_valid=0 and never wait; lanes < k retire normally.
REQ-010 exc_valid SHALL pulse one cycle at commit when any lane excepts or irq=1 at commit, with exc_ecode/era/badv from lane k (irq: EC_INT, lane-0 PC, badv 0); irq beats lane exceptions.
REQ-011 wb_we[i] = in_we[i] & retired; wb_rd/wb_data SHALL be 0 for non-writing lanes; dbg_valid[i] = 1 for each retired lane including those with in_we=0.
REQ-012 wb_*, dbg_valid, exc_valid SHALL be high for exactly one cycle per commit, zero otherwise.
REQ-013 in_ready = ~flush & (state==EMPTY | H commits this cycle); back-to-back no-pending bundles sustain one per cycle.
REQ-014 Latency: acceptance at edge E0; no-pending bundle commits at E1; pending bundle commits at the edge of the last strobe.
REQ-015 flush SHALL clear H to EMPTY without commit and drop the incoming bundle; flush beats a same-cycle commit.

Reset
REQ-016 rst SHALL force EMPTY, P=0, and all outputs to zero on the next edge, including mid-WAIT; in_ready=0 while rst=1.

Verification
REQ-017 Scenarios:
  Two alu lanes rd=3/4, data 0x11/0x22 -> one cycle later wb_we=2'b11, wb_data=0x22_0x11, dbg_valid=2'b11.
  Lane 1 div, div_valid 5 cycles later with 0x7 -> in_ready low meanwhile; commit at strobe edge, wb_data[1]=0x7.
  Lane 0 exc ecode 0x08 pc 0x1c000000, lane 1 load -> no wait; exc_valid pulse, era=0x1c000000, wb_we=0, dbg_valid=0.
  Lane 1 exc, lane 0 alu -> lane 0 writes, exc_era=lane-1 PC.
  flush during WAIT, then ld_valid -> no commit, strobe ignored, in_ready=1.
  rst asserted mid-WAIT -> all outputs 0, state EMPTY next edge.

Source files
------------

// File: rtl/wb_stage_multi.sv
// Multi-lane writeback stage. It holds one issue bundle until its divider and load
// results arrive, then retires it in a single cycle or raises the first exception.
module wb_stage_multi #(
   parameter int              NLANE  = 2,
   parameter int              XLEN   = 32,
   parameter int              RD_W   = 5,
   parameter int              EC_W   = 7,
   parameter logic [EC_W-1:0] EC_INT = 7'h00
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  irq,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NLANE*XLEN-1:0] in_pc,
   input  logic [NLANE*32-1:0]   in_inst,
   input  logic [NLANE*RD_W-1:0] in_rd,
   input  logic [NLANE-1:0]      in_we,
   input  logic [NLANE*2-1:0]    in_src,
   input  logic [NLANE*XLEN-1:0] in_alu,
   input  logic [NLANE-1:0]      in_exc,
   input  logic [NLANE*EC_W-1:0] in_ecode,
   input  logic [NLANE*XLEN-1:0] in_badv,
   input  logic [XLEN-1:0]       csr_data,
   input  logic                  div_valid,
   input  logic [XLEN-1:0]       div_data,
   input  logic                  ld_valid,
   input  logic [XLEN-1:0]       ld_data,
   output logic [NLANE-1:0]      wb_we,
   output logic [NLANE*RD_W-1:0] wb_rd,
   output logic [NLANE*XLEN-1:0] wb_data,
   output logic                  exc_valid,
   output logic [EC_W-1:0]       exc_ecode,
   output logic [XLEN-1:0]       exc_era,
   output logic [XLEN-1:0]       exc_badv,
   output logic [NLANE-1:0]      dbg_valid,
   output logic [NLANE*XLEN-1:0] dbg_pc,
   output logic [NLANE*32-1:0]   dbg_inst
);

   localparam logic [1:0] SRC_DIV = 2'd1;
   localparam logic [1:0] SRC_CSR = 2'd2;
   localparam logic [1:0] SRC_LD  = 2'd3;

   typedef enum logic {S_EMPTY, S_WAIT} state_t;

   state_t           state;
   logic [NLANE-1:0] h_pend, h_live, h_we;
   logic [1:0]       h_src  [NLANE];
   logic [XLEN-1:0]  h_pc   [NLANE];
   logic [31:0]      h_inst [NLANE];
   logic [RD_W-1:0]  h_rd   [NLANE];
   logic [XLEN-1:0]  h_data [NLANE];
   logic             h_exc;
   logic [EC_W-1:0]  h_ecode;
   logic [XLEN-1:0]  h_era, h_badv;

   logic [NLANE-1:0] pend_nx, retire, acc_live, acc_pend;
   logic [XLEN-1:0]  data_nx  [NLANE];
   logic [XLEN-1:0]  acc_data [NLANE];
   logic             acc_exc, commit, accept;
   logic [EC_W-1:0]  acc_ecode;
   logic [XLEN-1:0]  acc_era, acc_badv;

   // Strobes complete the matching pending lane; commit sees the post-strobe pending set.
   always_comb begin
      for (int i = 0; i < NLANE; i++) begin
         pend_nx[i] = h_pend[i];
         data_nx[i] = h_data[i];
         if (h_pend[i] && h_src[i] == SRC_DIV && div_valid) begin
            pend_nx[i] = 1'b0;
            data_nx[i] = div_data;
         end
         if (h_pend[i] && h_src[i] == SRC_LD && ld_valid) begin
            pend_nx[i] = 1'b0;
            data_nx[i] = ld_data;
         end
      end
      commit   = (state == S_WAIT) && (pend_nx == '0) && !flush && !rst;
      in_ready = !rst && !flush && ((state == S_EMPTY) || commit);
      accept   = in_valid && in_ready;
      retire   = h_live & {NLANE{~irq}};
   end

   // Lanes at or above the oldest excepting lane are dead and never wait.
   always_comb begin
      acc_exc   = 1'b0;
      acc_ecode = '0;
      acc_era   = '0;
      acc_badv  = '0;
      for (int i = 0; i < NLANE; i++) begin
         acc_live[i] = ~acc_exc & ~in_exc[i];
         if (in_exc[i] && !acc_exc) begin
            acc_ecode = in_ecode[i*EC_W +: EC_W];
            acc_era   = in_pc[i*XLEN +: XLEN];
            acc_badv  = in_badv[i*XLEN +: XLEN];
         end
         acc_exc     = acc_exc | in_exc[i];
         acc_pend[i] = acc_live[i] &
                       (in_src[i*2 +: 2] == SRC_DIV || in_src[i*2 +: 2] == SRC_LD);
         acc_data[i] = (in_src[i*2 +: 2] == SRC_CSR) ? csr_data : in_alu[i*XLEN +: XLEN];
      end
   end

   always_ff @(posedge clk) begin
      wb_we     <= '0;
      wb_rd     <= '0;
      wb_data   <= '0;
      exc_valid <= 1'b0;
      exc_ecode <= '0;
      exc_era   <= '0;
      exc_badv  <= '0;
      dbg_valid <= '0;
      dbg_pc    <= '0;
      dbg_inst  <= '0;
      if (rst) begin
         state  <= S_EMPTY;
         h_pend <= '0;
      end else if (flush) begin
         state  <= S_EMPTY;
         h_pend <= '0;
      end else begin
         if (state == S_WAIT) begin
            h_pend <= pend_nx;
            for (int i = 0; i < NLANE; i++) h_data[i] <= data_nx[i];
         end
         if (commit) begin
            state <= S_EMPTY;
            for (int i = 0; i < NLANE; i++) begin
               wb_we[i]                  <= h_we[i] & retire[i];
               wb_rd[i*RD_W +: RD_W]     <= (h_we[i] & retire[i]) ? h_rd[i] : '0;
               wb_data[i*XLEN +: XLEN]   <= (h_we[i] & retire[i]) ? data_nx[i] : '0;
               dbg_valid[i]              <= retire[i];
               dbg_pc[i*XLEN +: XLEN]    <= retire[i] ? h_pc[i] : '0;
               dbg_inst[i*32 +: 32]      <= retire[i] ? h_inst[i] : '0;
            end
            if (irq) begin
               exc_valid <= 1'b1;
               exc_ecode <= EC_INT;
               exc_era   <= h_pc[0];
            end else if (h_exc) begin
               exc_valid <= 1'b1;
               exc_ecode <= h_ecode;
               exc_era   <= h_era;
               exc_badv  <= h_badv;
            end
         end
         if (accept) begin
            state   <= S_WAIT;
            h_pend  <= acc_pend;
            h_live  <= acc_live;
            h_we    <= in_we;
            h_exc   <= acc_exc;
            h_ecode <= acc_ecode;
            h_era   <= acc_era;
            h_badv  <= acc_badv;
            for (int i = 0; i < NLANE; i++) begin
               h_src[i]  <= in_src[i*2 +: 2];
               h_pc[i]   <= in_pc[i*XLEN +: XLEN];
               h_inst[i] <= in_inst[i*32 +: 32];
               h_rd[i]   <= in_rd[i*RD_W +: RD_W];
               h_data[i] <= acc_data[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_stage_multi.sv
// Directed bench for wb_stage_multi: expected commit records are queued when a bundle
// is offered and compared whenever the stage drives a nonzero writeback/debug/exception.
module tb_wb_stage_multi;

   localparam int NL = 2;
   localparam int XL = 32;
   localparam int RW = 5;
   localparam int EW = 7;
   localparam int W  = NL + NL*RW + NL*XL + 1 + EW + XL + XL + NL + NL*XL + NL*32;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           flush = 1'b0, irq = 1'b0, in_valid = 1'b0, in_ready;
   logic [NL*XL-1:0] in_pc = '0, in_alu = '0, in_badv = '0;
   logic [NL*32-1:0] in_inst = '0;
   logic [NL*RW-1:0] in_rd = '0;
   logic [NL-1:0]    in_we = '0, in_exc = '0;
   logic [NL*2-1:0]  in_src = '0;
   logic [NL*EW-1:0] in_ecode = '0;
   logic [XL-1:0]    csr_data = '0, div_data = '0, ld_data = '0;
   logic             div_valid = 1'b0, ld_valid = 1'b0;
   logic [NL-1:0]    wb_we, dbg_valid;
   logic [NL*RW-1:0] wb_rd;
   logic [NL*XL-1:0] wb_data, dbg_pc;
   logic [NL*32-1:0] dbg_inst;
   logic             exc_valid;
   logic [EW-1:0]    exc_ecode;
   logic [XL-1:0]    exc_era, exc_badv;

   wb_stage_multi dut (
      .clk(clk), .rst(rst), .flush(flush), .irq(irq),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .in_rd(in_rd), .in_we(in_we),
      .in_src(in_src), .in_alu(in_alu), .in_exc(in_exc), .in_ecode(in_ecode),
      .in_badv(in_badv), .csr_data(csr_data),
      .div_valid(div_valid), .div_data(div_data), .ld_valid(ld_valid), .ld_data(ld_data),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .exc_valid(exc_valid), .exc_ecode(exc_ecode), .exc_era(exc_era), .exc_badv(exc_badv),
      .dbg_valid(dbg_valid), .dbg_pc(dbg_pc), .dbg_inst(dbg_inst)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic mon_on = 1'b0;
   logic [W-1:0] exp_q[$];

   // Bundle under construction
   logic [XL-1:0] b_pc[NL], b_alu[NL], b_badv[NL];
   logic [31:0]   b_inst[NL];
   logic [RW-1:0] b_rd[NL];
   logic [1:0]    b_src[NL];
   logic [EW-1:0] b_ecode[NL];
   logic          b_we[NL], b_exc[NL];

   function automatic logic [W-1:0] obs_pack();
      return {wb_we, wb_rd, wb_data, exc_valid, exc_ecode, exc_era, exc_badv,
              dbg_valid, dbg_pc, dbg_inst};
   endfunction

   // Reference model of one commit from the bundle fields and resolved results.
   function automatic logic [W-1:0] model(input logic irq_c, input logic [XL-1:0] csr,
                                          input logic [XL-1:0] dv, input logic [XL-1:0] lv);
      logic [NL-1:0] we_o = '0, dv_o = '0;
      logic [NL*RW-1:0] rd_o = '0;
      logic [NL*XL-1:0] data_o = '0, pc_o = '0;
      logic [NL*32-1:0] inst_o = '0;
      logic ev = 1'b0, seen = 1'b0, live;
      logic [EW-1:0] ec = '0;
      logic [XL-1:0] era = '0, badv = '0, d;
      for (int i = 0; i < NL; i++) begin
         live = !seen && !b_exc[i] && !irq_c;
         if (b_exc[i] && !seen) begin
            ev = 1'b1; ec = b_ecode[i]; era = b_pc[i]; badv = b_badv[i];
         end
         seen = seen | b_exc[i];
         case (b_src[i])
            2'd1:    d = dv;
            2'd2:    d = csr;
            2'd3:    d = lv;
            default: d = b_alu[i];
         endcase
         if (live) begin
            dv_o[i] = 1'b1;
            pc_o[i*XL +: XL] = b_pc[i];
            inst_o[i*32 +: 32] = b_inst[i];
            if (b_we[i]) begin
               we_o[i] = 1'b1;
               rd_o[i*RW +: RW] = b_rd[i];
               data_o[i*XL +: XL] = d;
            end
         end
      end
      if (irq_c) begin
         ev = 1'b1; ec = 7'h00; era = b_pc[0]; badv = '0;
      end
      return {we_o, rd_o, data_o, ev, ec, era, badv, dv_o, pc_o, inst_o};
   endfunction

   task automatic set_lane(input int i, input logic [XL-1:0] pc, input logic [RW-1:0] rd,
                           input logic we, input logic [1:0] src, input logic [XL-1:0] alu,
                           input logic exc, input logic [EW-1:0] ec);
      b_pc[i] = pc; b_rd[i] = rd; b_we[i] = we; b_src[i] = src; b_alu[i] = alu;
      b_exc[i] = exc; b_ecode[i] = ec;
      b_inst[i] = $urandom_range(32'hffff_ffff);
      b_badv[i] = $urandom_range(32'hffff_ffff);
   endtask

   task automatic apply();
      for (int i = 0; i < NL; i++) begin
         in_pc[i*XL +: XL] = b_pc[i];     in_alu[i*XL +: XL] = b_alu[i];
         in_badv[i*XL +: XL] = b_badv[i]; in_inst[i*32 +: 32] = b_inst[i];
         in_rd[i*RW +: RW] = b_rd[i];     in_we[i] = b_we[i];
         in_src[i*2 +: 2] = b_src[i];     in_exc[i] = b_exc[i];
         in_ecode[i*EW +: EW] = b_ecode[i];
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Offer the bundle for one cycle; in_ready is sampled mid-cycle.
   task automatic send(input string tag, input logic exp_ready);
      int ndiv = 0, nld = 0;
      for (int i = 0; i < NL; i++) begin
         if (b_src[i] == 2'd1) ndiv++;
         if (b_src[i] == 2'd3) nld++;
      end
      assert (ndiv <= 1 && nld <= 1) else $error("bundle has more than one div or load lane");
      apply();
      in_valid = 1'b1;
      @(negedge clk);
      chk1(tag, in_ready, exp_ready);
      tick();
      in_valid = 1'b0;
      in_exc = '0;
   endtask

   task automatic drain(input string tag);
      repeat (2) @(posedge clk);
      #1;
      chk_int(tag, exp_q.size(), 0);
   endtask

   // Monitor: any nonzero output cycle must match the oldest expected commit.
   initial begin
      logic [W-1:0] obs, exp;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            obs = obs_pack();
            if (obs !== '0) begin
               exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
               n_checks++;
               assert (obs === exp) else begin
                  n_fail++;
                  $error("FAIL commit obs=%h exp=%h", obs, exp);
               end
            end
         end
      end
   end

   initial begin
      logic [XL-1:0] v, v2;
      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk1("rst_in_ready", in_ready, 1'b0);
      n_checks++;
      assert (obs_pack() === '0) else begin
         n_fail++;
         $error("FAIL rst_outputs obs=%h exp=0", obs_pack());
      end
      @(posedge clk); #1;
      rst = 1'b0;
      mon_on = 1'b1;

      // Two alu lanes, then a back-to-back bundle during the first commit
      set_lane(0, 32'h1c00_0000, 5'd3, 1'b1, 2'd0, 32'h11, 1'b0, '0);
      set_lane(1, 32'h1c00_0004, 5'd4, 1'b1, 2'd0, 32'h22, 1'b0, '0);
      exp_q.push_back(model(1'b0, '0, '0, '0));
      send("alu2_ready", 1'b1);
      set_lane(0, 32'h1c00_0008, 5'd9, 1'b1, 2'd0, $urandom_range(32'hffff_ffff), 1'b0, '0);
      set_lane(1, 32'h1c00_000c, 5'd0, 1'b0, 2'd0, $urandom_range(32'hffff_ffff), 1'b0, '0);
      exp_q.push_back(model(1'b0, '0, '0, '0));
      send("b2b_ready", 1'b1);
      drain("b2b_drain");

      // Lane 1 divider, strobe five cycles after acceptance; stray load strobe ignored
      set_lane(0, 32'h1c00_0010, 5'd5, 1'b1, 2'd0, $urandom_range(32'hffff_ffff), 1'b0, '0);
      set_lane(1, 32'h1c00_0014, 5'd7, 1'b1, 2'd1, 32'hdead_beef, 1'b0, '0);
      exp_q.push_back(model(1'b0, '0, 32'h7, '0));
      send("div_ready", 1'b1);
      for (int c = 0; c < 4; c++) begin
         ld_valid = (c == 1);
         ld_data = $urandom_range(32'hffff_ffff);
         @(negedge clk);
         chk1("div_wait_ready", in_ready, 1'b0);
         tick();
      end
      ld_valid = 1'b0;
      chk_int("div_not_early", exp_q.size(), 1);
      div_valid = 1'b1; div_data = 32'h7;
      @(negedge clk);
      chk1("div_strobe_ready", in_ready, 1'b1);
      tick();
      div_valid = 1'b0;
      drain("div_drain");

      // Lane 0 exception kills lane 1 load: no wait
      set_lane(0, 32'h1c00_0000, 5'd1, 1'b1, 2'd0, 32'h55, 1'b1, 7'h08);
      set_lane(1, 32'h1c00_0004, 5'd2, 1'b1, 2'd3, 32'h0, 1'b0, '0);
      exp_q.push_back(model(1'b0, '0, '0, '0));
      send("exc0_ready", 1'b1);
      @(negedge clk);
      chk1("exc0_no_wait", in_ready, 1'b1);
      drain("exc0_drain");

      // Lane 1 exception, lane 0 alu retires
      set_lane(0, 32'h1c00_0020, 5'd6, 1'b1, 2'd0, $urandom_range(32'hffff_ffff), 1'b0, '0);
      set_lane(1, 32'h1c00_0024, 5'd8, 1'b1, 2'd0, 32'h0, 1'b1, 7'h0d);
      exp_q.push_back(model(1'b0, '0, '0, '0));
      send("exc1_ready", 1'b1);
      drain("exc1_drain");

      // csr lane captures csr_data at acceptance only
      v = $urandom_range(32'hffff_ffff);
      csr_data = v;
      set_lane(0, 32'h1c00_0030, 5'd10, 1'b1, 2'd2, 32'h0, 1'b0, '0);
      set_lane(1, 32'h1c00_0034, 5'd11, 1'b0, 2'd0, 32'h99, 1'b0, '0);
      exp_q.push_back(model(1'b0, v, '0, '0));
      send("csr_ready", 1'b1);
      csr_data = ~v;
      drain("csr_drain");

      // Div and load lanes, strobes on separate cycles; commit on the later one
      v = $urandom_range(32'hffff_ffff);
      v2 = $urandom_range(32'hffff_ffff);
      set_lane(0, 32'h1c00_0040, 5'd12, 1'b1, 2'd1, 32'h0, 1'b0, '0);
      set_lane(1, 32'h1c00_0044, 5'd13, 1'b1, 2'd3, 32'h0, 1'b0, '0);
      exp_q.push_back(model(1'b0, '0, v, v2));
      send("dl_ready", 1'b1);
      ld_valid = 1'b1; ld_data = v2;
      @(negedge clk);
      chk1("dl_after_ld_ready", in_ready, 1'b0);
      tick();
      ld_valid = 1'b0;
      tick();
      chk_int("dl_not_early", exp_q.size(), 1);
      div_valid = 1'b1; div_data = v;
      @(negedge clk);
      chk1("dl_commit_ready", in_ready, 1'b1);
      tick();
      div_valid = 1'b0;
      drain("dl_drain");

      // Interrupt at commit kills every lane
      set_lane(0, 32'h1c00_0050, 5'd14, 1'b1, 2'd0, $urandom_range(32'hffff_ffff), 1'b0, '0);
      set_lane(1, 32'h1c00_0054, 5'd15, 1'b1, 2'd0, $urandom_range(32'hffff_ffff), 1'b1, 7'h11);
      exp_q.push_back(model(1'b1, '0, '0, '0));
      send("irq_ready", 1'b1);
      irq = 1'b1;
      tick();
      irq = 1'b0;
      drain("irq_drain");

      // Flush during WAIT drops both held and incoming bundles; later strobe ignored
      set_lane(0, 32'h1c00_0060, 5'd16, 1'b1, 2'd3, 32'h0, 1'b0, '0);
      set_lane(1, 32'h1c00_0064, 5'd17, 1'b1, 2'd0, 32'h1, 1'b0, '0);
      send("flush_ready", 1'b1);
      tick();
      set_lane(0, 32'h1c00_0070, 5'd18, 1'b1, 2'd0, 32'h2, 1'b0, '0);
      apply();
      flush = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      chk1("flush_in_ready", in_ready, 1'b0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      ld_valid = 1'b1; ld_data = 32'h1234_5678;
      @(negedge clk);
      chk1("flush_empty_ready", in_ready, 1'b1);
      tick();
      ld_valid = 1'b0;
      drain("flush_drain");

      // Reset mid-WAIT
      set_lane(0, 32'h1c00_0080, 5'd19, 1'b1, 2'd0, 32'h3, 1'b0, '0);
      set_lane(1, 32'h1c00_0084, 5'd20, 1'b1, 2'd1, 32'h0, 1'b0, '0);
      send("rstw_ready", 1'b1);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk1("rstw_in_ready", in_ready, 1'b0);
      tick();
      rst = 1'b0;
      n_checks++;
      assert (obs_pack() === '0) else begin
         n_fail++;
         $error("FAIL rstw_outputs obs=%h exp=0", obs_pack());
      end
      div_valid = 1'b1; div_data = 32'h77;
      @(negedge clk);
      chk1("rstw_empty_ready", in_ready, 1'b1);
      tick();
      div_valid = 1'b0;

      // Normal operation after reset
      set_lane(0, 32'h1c00_0090, 5'd21, 1'b1, 2'd0, $urandom_range(32'hffff_ffff), 1'b0, '0);
      set_lane(1, 32'h1c00_0094, 5'd22, 1'b1, 2'd0, $urandom_range(32'hffff_ffff), 1'b0, '0);
      exp_q.push_back(model(1'b0, '0, '0, '0));
      send("post_rst_ready", 1'b1);
      drain("post_rst_drain");

      repeat (3) @(posedge clk);
      #1;
      chk_int("final_queue", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
